truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential, parametrised successor to the team's exhaustive truth-table benches for 3/4-variable combinational functions.
- Steps an N-input combinational DUT through all 2^N input vectors in ascending order and holds each vector for a programmable settle time.
- Samples the DUT's single-bit output for each vector, builds the captured truth table, and compares it against a golden table latched at start.
- Reports a pass flag, a mismatch count and the first failing vector index. Sits beside the DUT in benches and in on-chip self-test wrappers.

Parameters:
- N_IN, 4, number of DUT inputs, legal range 1..8
- SETTLE, 1, clock cycles each vector is held before its output is sampled, legal range >= 1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  sweep request; accepted only in IDLE
- abort  input  1  synchronous abort of a running sweep
- expected  input  2^N_IN  golden truth table; bit k = required y for vector k; latched on start acceptance
- vec_out  output  N_IN  vector driven to the DUT; MSB is the first variable (a)
- y_in  input  1  DUT output
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when a sweep completes (not asserted on abort)
- captured  output  2^N_IN  sampled truth table; bit k = y_in sampled for vector k
- mismatch_cnt  output  N_IN+1  number of vectors where captured differs from expected
- first_fail  output  N_IN  index of the lowest mismatching vector; 0 when none
- fail_seen  output  1  at least one mismatch in the current or last sweep
- pass  output  1  set together with done when mismatch_cnt==0; held until the next start

Behaviour:
- Reset (async, immediate): state=IDLE; vec_out, busy, done, captured, mismatch_cnt, first_fail, fail_seen, pass all 0; internal index and settle counter 0.
- FSM states are IDLE, SWEEP, FINISH.
- IDLE:
  - On an edge with start=1: latch expected, clear captured/mismatch_cnt/first_fail/fail_seen/pass, set vec_out=0, busy=1, settle counter=0, go to SWEEP.
- SWEEP:
  - The settle counter increments every cycle.
  - On the edge where the counter reaches SETTLE-1 (the sample edge), y_in is written into captured[idx].
  - If y_in != expected_latched[idx]: mismatch_cnt+1. If fail_seen==0, also set first_fail=idx and fail_seen=1.
  - On the same sample edge, if idx < 2^N_IN-1: idx+1, vec_out=idx+1, counter=0.
  - Else go to FINISH; busy=0, vec_out=0.
  - Each vector is therefore driven for exactly SETTLE cycles. Vector k is sampled at edge (start edge + (k+1)*SETTLE). busy is high for exactly 2^N_IN*SETTLE cycles.
- FINISH (one cycle): done=1; pass = (mismatch_cnt==0); next state IDLE. done is low in all other states.
- abort=1 in SWEEP takes priority over sampling on that edge:
  - Next state IDLE, busy=0, vec_out=0, no done.
  - pass stays 0; partial captured, mismatch_cnt and first_fail are retained.
- abort in IDLE or FINISH: no effect.
- start while busy or in FINISH: ignored. A start in the cycle right after done is accepted.
- expected changes while busy: no effect, because the table was latched at start.
- Width rules:
  - mismatch_cnt saturates naturally (max 2^N_IN, fits in N_IN+1 bits).
  - The index counter must not wrap during a sweep. For N_IN=8 the last vector is 255 and FINISH follows.

Test Plan:
- N_IN=4, SETTLE=1; bench DUT y=(a&b)|(c&~d); expected=16'hF444; pulse start -> busy high 16 cycles, vec_out 0..15 one per cycle, done pulse on the 17th edge after the start edge; captured=16'hF444, mismatch_cnt=0, fail_seen=0, pass=1.
- Same DUT, expected=16'h7445 -> mismatch_cnt=2, first_fail=0, fail_seen=1, pass=0 at done; captured=16'hF444.
- SETTLE=3, DUT with output through 2 register stages -> pass=1, busy for 48 cycles. Same DUT with SETTLE=1 -> pass=0, mismatch_cnt>0.
- abort asserted while vec_out=4 -> busy=0 and vec_out=0 on the next edge, no done, pass=0, captured bits 0..3 valid. Then restart with start -> full sweep completes with pass=1.
- rst asserted mid-sweep (vec_out=9) -> all outputs 0 immediately, without a clock edge. start pulses during busy -> ignored, sweep length unchanged.
- N_IN=1, SETTLE=1, DUT y=~a, expected=2'b01 -> vec_out 0 then 1, done on the 3rd edge after start, captured=2'b01, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweeper for an N_IN-input single-output DUT
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_seen,
    output logic                 pass
);

    localparam int DEPTH = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

    state_t             state, state_n;
    logic [N_IN-1:0]    idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DEPTH-1:0]   exp_q, exp_n;
    logic [N_IN-1:0]    vec_n;
    logic               busy_n, done_n, fs_n, pass_n;
    logic [DEPTH-1:0]   cap_n;
    logic [N_IN:0]      mm_n;
    logic [N_IN-1:0]    ff_n;

    logic sample;
    logic last;

    assign sample = (cnt == CNT_W'(SETTLE - 1));
    assign last   = (idx == N_IN'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            exp_q        <= '0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            captured     <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_seen    <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            exp_q        <= exp_n;
            vec_out      <= vec_n;
            busy         <= busy_n;
            done         <= done_n;
            captured     <= cap_n;
            mismatch_cnt <= mm_n;
            first_fail   <= ff_n;
            fail_seen    <= fs_n;
            pass         <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        exp_n   = exp_q;
        vec_n   = vec_out;
        busy_n  = busy;
        done_n  = 1'b0;
        cap_n   = captured;
        mm_n    = mismatch_cnt;
        ff_n    = first_fail;
        fs_n    = fail_seen;
        pass_n  = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    exp_n   = expected;
                    cap_n   = '0;
                    mm_n    = '0;
                    ff_n    = '0;
                    fs_n    = 1'b0;
                    pass_n  = 1'b0;
                    vec_n   = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SWEEP;
                end
            end
            SWEEP: begin
                // Abort wins over the sample on the same edge; partial results stay visible.
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    vec_n   = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (sample) begin
                        cap_n[idx] = y_in;
                        if (y_in != exp_q[idx]) begin
                            mm_n = mismatch_cnt + 1'b1;
                            if (!fail_seen) begin
                                ff_n = idx;
                                fs_n = 1'b1;
                            end
                        end
                        if (!last) begin
                            idx_n = idx + 1'b1;
                            vec_n = idx + 1'b1;
                            cnt_n = '0;
                        end else begin
                            state_n = FINISH;
                            busy_n  = 1'b0;
                            vec_n   = '0;
                            idx_n   = '0;
                            cnt_n   = '0;
                        end
                    end
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                pass_n  = (mismatch_cnt == '0);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic clk;
    logic rst;
    logic [3:0] start_v;
    logic abort4;
    logic abort_z;

    logic [15:0] dut_tab;
    logic [15:0] reg_tab;

    // instance 0: N_IN=4, SETTLE=1, combinational lookup DUT
    logic [15:0] exp4, cap4;
    logic [3:0]  vec4, ff4;
    logic [4:0]  mm4;
    logic        y4, busy4, done4, fail4, pass4;

    // instance 1: N_IN=4, SETTLE=3, DUT with two register stages
    logic [15:0] exp3, cap3;
    logic [3:0]  vec3, ff3;
    logic [4:0]  mm3;
    logic        y3, busy3, done3, fail3, pass3;
    logic        r1_3, r2_3;

    // instance 2: N_IN=4, SETTLE=1, same registered DUT
    logic [15:0] expr, capr;
    logic [3:0]  vecr, ffr;
    logic [4:0]  mmr;
    logic        yr, busyr, doner, failr, passr;
    logic        r1_r, r2_r;

    // instance 3: N_IN=1, SETTLE=1, y = ~a
    logic [1:0]  exp1, cap1;
    logic [0:0]  vec1, ff1;
    logic [1:0]  mm1;
    logic        y1, busy1, done1, fail1, pass1;

    int checks = 0;
    int errors = 0;

    logic [3:0] busy_w, done_w;
    logic [7:0] vec_w [4];

    assign y4 = dut_tab[vec4];
    assign y3 = r2_3;
    assign yr = r2_r;
    assign y1 = ~vec1[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_3 <= 1'b0; r2_3 <= 1'b0; r1_r <= 1'b0; r2_r <= 1'b0;
        end else begin
            r1_3 <= reg_tab[vec3]; r2_3 <= r1_3;
            r1_r <= reg_tab[vecr]; r2_r <= r1_r;
        end
    end

    assign busy_w = {busy1, busyr, busy3, busy4};
    assign done_w = {done1, doner, done3, done4};
    assign vec_w[0] = 8'(vec4);
    assign vec_w[1] = 8'(vec3);
    assign vec_w[2] = 8'(vecr);
    assign vec_w[3] = 8'(vec1);

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort4), .expected(exp4),
        .vec_out(vec4), .y_in(y4), .busy(busy4), .done(done4), .captured(cap4),
        .mismatch_cnt(mm4), .first_fail(ff4), .fail_seen(fail4), .pass(pass4));

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_z), .expected(exp3),
        .vec_out(vec3), .y_in(y3), .busy(busy3), .done(done3), .captured(cap3),
        .mismatch_cnt(mm3), .first_fail(ff3), .fail_seen(fail3), .pass(pass3));

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) ur (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_z), .expected(expr),
        .vec_out(vecr), .y_in(yr), .busy(busyr), .done(doner), .captured(capr),
        .mismatch_cnt(mmr), .first_fail(ffr), .fail_seen(failr), .pass(passr));

    truth_table_sweeper #(.N_IN(1), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[3]), .abort(abort_z), .expected(exp1),
        .vec_out(vec1), .y_in(y1), .busy(busy1), .done(done1), .captured(cap1),
        .mismatch_cnt(mm1), .first_fail(ff1), .fail_seen(fail1), .pass(pass1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dtab;
        logic [15:0] etab;
        int          cnt;
        int          ff;
        bit          pass;
    } vec_t;

    vec_t tv [5];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: mismatches are the set bits of dut^expected; first fail is the lowest one.
    function automatic int lowest_set(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic run_sweep(input int inst, input int settle, input int nvec, input bit mid_start,
                             output int busy_cyc, output int done_at, output bit seq_ok);
        busy_cyc = 0;
        done_at  = -1;
        seq_ok   = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        for (int i = 0; i < nvec * settle + 10; i++) begin
            if (busy_w[inst]) begin
                busy_cyc++;
                if (int'(vec_w[inst]) != i / settle) seq_ok = 1'b0;
            end else if (vec_w[inst] != 8'd0) begin
                seq_ok = 1'b0;
            end
            if (done_w[inst]) begin
                if (done_at < 0) done_at = i;
                else seq_ok = 1'b0;
            end
            if (mid_start && i == 5) start_v[inst] = 1'b1;
            if (mid_start && i == 6) start_v[inst] = 1'b0;
            if (inst == 0 && i == 3) exp4 = 16'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        int  bc, da, cnt, ff;
        bit  ok, done_seen;
        logic [15:0] dt, et, delayed;

        tv[0] = '{16'hF444, 16'hF444, 0, 0, 1'b1};
        tv[1] = '{16'hF444, 16'h7445, 2, 0, 1'b0};
        tv[2] = '{16'h0000, 16'hFFFF, 16, 0, 1'b0};
        tv[3] = '{16'h0000, 16'h8000, 1, 15, 1'b0};
        tv[4] = '{16'h1234, 16'h1274, 1, 6, 1'b0};

        rst = 1'b1; start_v = '0; abort4 = 1'b0; abort_z = 1'b0;
        dut_tab = 16'hF444; reg_tab = 16'hF444;
        exp4 = '0; exp3 = 16'hF444; expr = 16'hF444; exp1 = 2'b01;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy4, 0);
        chk("rst_vec", vec4, 0);
        chk("rst_done", done4, 0);
        chk("rst_outs", {cap4, mm4, ff4, fail4, pass4}, 0);
        rst = 1'b0;

        foreach (tv[t]) begin
            dut_tab = tv[t].dtab;
            exp4    = tv[t].etab;
            run_sweep(0, 1, 16, t == 2, bc, da, ok);
            chk($sformatf("tv%0d_busy_len", t), bc, 16);
            chk($sformatf("tv%0d_done_at", t), da, 17);
            chk($sformatf("tv%0d_seq", t), ok, 1);
            chk($sformatf("tv%0d_captured", t), cap4, tv[t].dtab);
            chk($sformatf("tv%0d_mismatch", t), mm4, tv[t].cnt);
            chk($sformatf("tv%0d_first_fail", t), ff4, tv[t].ff);
            chk($sformatf("tv%0d_fail_seen", t), fail4, tv[t].cnt != 0);
            chk($sformatf("tv%0d_pass", t), pass4, tv[t].pass);
        end

        for (int it = 0; it < 10; it++) begin
            dt = 16'($urandom);
            et = (it % 3 == 0) ? dt : dt ^ 16'($urandom & $urandom);
            dut_tab = dt;
            exp4    = et;
            cnt = $countones(dt ^ et);
            ff  = lowest_set(dt ^ et);
            run_sweep(0, 1, 16, 1'b0, bc, da, ok);
            chk($sformatf("rnd%0d_done_at", it), da, 17);
            chk($sformatf("rnd%0d_captured", it), cap4, dt);
            chk($sformatf("rnd%0d_mismatch", it), mm4, cnt);
            chk($sformatf("rnd%0d_first_fail", it), ff4, ff);
            chk($sformatf("rnd%0d_pass", it), pass4, cnt == 0);
        end

        // abort while vector 4 is driven
        dut_tab = 16'hF444;
        exp4    = 16'h7445;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        for (int k = 0; k < 40 && vec4 != 4'd4; k++) @(negedge clk);
        chk("abort_reach_vec4", vec4, 4);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        chk("abort_busy", busy4, 0);
        chk("abort_vec", vec4, 0);
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done4) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_pass", pass4, 0);
        chk("abort_captured", cap4, 16'h0004);
        chk("abort_mismatch", mm4, 1);
        chk("abort_first_fail", ff4, 0);
        exp4 = 16'hF444;
        run_sweep(0, 1, 16, 1'b0, bc, da, ok);
        chk("restart_done_at", da, 17);
        chk("restart_pass", pass4, 1);
        chk("restart_captured", cap4, 16'hF444);

        // asynchronous reset mid-sweep
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        for (int k = 0; k < 40 && vec4 != 4'd9; k++) @(negedge clk);
        chk("rst_reach_vec9", vec4, 9);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy4, 0);
        chk("arst_vec", vec4, 0);
        chk("arst_captured", cap4, 0);
        chk("arst_outs", {mm4, ff4, fail4, pass4, done4}, 0);
        rst = 1'b0;

        // registered DUT, SETTLE=3: latency hidden by settle time
        run_sweep(1, 3, 16, 1'b0, bc, da, ok);
        chk("s3_busy_len", bc, 48);
        chk("s3_done_at", da, 49);
        chk("s3_seq", ok, 1);
        chk("s3_captured", cap3, 16'hF444);
        chk("s3_pass", pass3, 1);

        // registered DUT, SETTLE=1: each sample sees the value from two vectors earlier
        for (int k = 0; k < 16; k++) delayed[k] = reg_tab[(k < 2) ? 0 : k - 2];
        run_sweep(2, 1, 16, 1'b0, bc, da, ok);
        chk("s1r_done_at", da, 17);
        chk("s1r_captured", capr, delayed);
        chk("s1r_mismatch", mmr, $countones(delayed ^ 16'hF444));
        chk("s1r_nonzero", mmr > 0, 1);
        chk("s1r_pass", passr, 0);

        // single-input DUT
        run_sweep(3, 1, 2, 1'b0, bc, da, ok);
        chk("n1_busy_len", bc, 2);
        chk("n1_done_at", da, 3);
        chk("n1_seq", ok, 1);
        chk("n1_captured", cap1, 2'b01);
        chk("n1_pass", pass1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
